nav_sequencer: RTL and testbench

Path-level controller for the line-following drive datapath. It passes the line follower's wheel commands through while tracking the line. It detects nodes, where all three reflectance sensors read dark. At each node it executes the next command from a small programmable path table: straight, left turn, right turn or stop. It sits between the ADC sampler/line follower and the motor PWM stage, and owns the final speed/direction to the motors.

---
 rtl/nav_pkg.sv | 22 ++
 rtl/nav_sequencer_node_detect.sv | 37 +++
 rtl/nav_sequencer.sv | 163 ++++++++++++++++
 tb/tb_nav_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nav_pkg.sv
// Shared types and constants for the path-level navigation sequencer.
package nav_pkg;

  typedef enum logic [1:0] {
    CMD_STRAIGHT = 2'b00,
    CMD_LEFT     = 2'b01,
    CMD_RIGHT    = 2'b10,
    CMD_STOP     = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FOLLOW = 3'd1,
    CROSS  = 3'd2,
    TURN   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [13:0] TURN_SPEED = 14'd5500;
  localparam int          CYC_W      = 27;

endpackage

// File: rtl/nav_sequencer_node_detect.sv
// Node detector: all three sensors dark for NODE_DEBOUNCE consecutive valid samples.
module node_detect
  import nav_pkg::*;
#(
  parameter int DARK_TH       = 1500,
  parameter int NODE_DEBOUNCE = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        adc_valid,
  input  logic [11:0] in0,
  input  logic [11:0] in1,
  input  logic [11:0] in2,
  output logic        node
);

  localparam int CW = $clog2(NODE_DEBOUNCE + 1);

  logic [CW-1:0] run_cnt;
  logic          dark_all;

  assign dark_all = (in0 >= 12'(DARK_TH)) && (in1 >= 12'(DARK_TH)) && (in2 >= 12'(DARK_TH));
  assign node     = (run_cnt == CW'(NODE_DEBOUNCE));

  // The pulse lasts one cycle because reaching the count forces a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (clear || node) begin
      run_cnt <= '0;
    end else if (adc_valid) begin
      run_cnt <= dark_all ? run_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/nav_sequencer.sv
// Path-level drive controller: follows the line, runs the path table at nodes.
// NAV_ERR_TIMEOUT_EN enables the turn timeout (DONE with err=1 after TURN_MAX clocks).
module nav_sequencer
  import nav_pkg::*;
#(
  parameter int DARK_TH       = 1500,
  parameter int NODE_DEBOUNCE = 3,
  parameter int CROSS_CYCLES  = 5_000_000,
  parameter int TURN_MIN      = 15_000_000,
  parameter int TURN_MAX      = 100_000_000,
  parameter int PATH_LEN      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        adc_valid,
  input  logic [11:0]                 in0,
  input  logic [11:0]                 in1,
  input  logic [11:0]                 in2,
  input  logic [13:0]                 lf_speed_l,
  input  logic [13:0]                 lf_speed_r,
  input  logic                        lf_dir_l,
  input  logic                        lf_dir_r,
  input  logic                        path_wr_en,
  input  logic [$clog2(PATH_LEN)-1:0] path_wr_addr,
  input  logic [1:0]                  path_wr_cmd,
  output logic [13:0]                 speed_l,
  output logic [13:0]                 speed_r,
  output logic                        dir_l,
  output logic                        dir_r,
  output logic                        busy,
  output logic                        done,
  output logic [3:0]                  node_cnt,
  output logic                        err,
  output logic [2:0]                  state_dbg
);

  localparam int               IW         = $clog2(PATH_LEN);
  localparam logic [IW:0]      IDX_END    = (IW+1)'(PATH_LEN);
  localparam logic [CYC_W-1:0] CROSS_LAST = CYC_W'(CROSS_CYCLES - 1);
  localparam logic [CYC_W-1:0] TURN_MIN_C = CYC_W'(TURN_MIN);
  localparam logic [CYC_W-1:0] TURN_LAST  = CYC_W'(TURN_MAX - 1);
`ifdef NAV_ERR_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_t           state, state_nxt;
  cmd_t             path_tab [PATH_LEN];
  cmd_t             cur_cmd, tab_cmd;
  logic [IW:0]      idx;
  logic [CYC_W-1:0] cyc_cnt;
  logic             node, entry, start_go, centre_dark, turn_timeout, err_q;

  assign tab_cmd      = path_tab[idx[IW-1:0]];
  assign entry        = (state_nxt != state);
  assign centre_dark  = adc_valid && (in1 >= 12'(DARK_TH));
  assign turn_timeout = TIMEOUT_EN && (cyc_cnt == TURN_LAST);
  assign err          = err_q;
  assign state_dbg    = state;

  node_detect #(.DARK_TH(DARK_TH), .NODE_DEBOUNCE(NODE_DEBOUNCE)) u_node_detect (
    .clk(clk), .rst_n(rst_n), .clear(entry), .adc_valid(adc_valid),
    .in0(in0), .in1(in1), .in2(in2), .node(node)
  );

  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_nxt = FOLLOW;
        start_go  = 1'b1;
      end
      FOLLOW: if (node) begin
        state_nxt = (idx == IDX_END || tab_cmd == CMD_STOP) ? DONE : CROSS;
      end
      CROSS: if (cyc_cnt == CROSS_LAST) begin
        state_nxt = (cur_cmd == CMD_STRAIGHT) ? FOLLOW : TURN;
      end
      TURN: begin
        if (cyc_cnt >= TURN_MIN_C && centre_dark) state_nxt = FOLLOW;
        else if (turn_timeout)                     state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      cur_cmd  <= CMD_STRAIGHT;
      cyc_cnt  <= '0;
      node_cnt <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < PATH_LEN; i++) path_tab[i] <= CMD_STOP;
    end else begin
      state   <= state_nxt;
      cyc_cnt <= entry ? '0 : ((cyc_cnt != '1) ? cyc_cnt + 1'b1 : cyc_cnt);
      if ((state == IDLE || state == DONE) && path_wr_en) begin
        path_tab[path_wr_addr] <= cmd_t'(path_wr_cmd);
      end
      if (start_go) begin
        idx      <= '0;
        node_cnt <= '0;
        err_q    <= 1'b0;
      end else begin
        if (state == FOLLOW && node) begin
          if (node_cnt != 4'hf) node_cnt <= node_cnt + 1'b1;
          if (state_nxt == CROSS) begin
            cur_cmd <= tab_cmd;
            idx     <= idx + 1'b1;
          end
        end
        // TURN only falls to DONE through the timeout.
        if (state == TURN && state_nxt == DONE) err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_l <= '0;
      speed_r <= '0;
      dir_l   <= 1'b0;
      dir_r   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (state == FOLLOW) || (state == CROSS) || (state == TURN);
      done <= (state == DONE);
      case (state)
        FOLLOW: begin
          speed_l <= lf_speed_l;
          speed_r <= lf_speed_r;
          dir_l   <= lf_dir_l;
          dir_r   <= lf_dir_r;
        end
        CROSS: begin
          speed_l <= TURN_SPEED;
          speed_r <= TURN_SPEED;
          dir_l   <= 1'b1;
          dir_r   <= 1'b1;
        end
        TURN: begin
          speed_l <= TURN_SPEED;
          speed_r <= TURN_SPEED;
          dir_l   <= (cur_cmd != CMD_LEFT);
          dir_r   <= (cur_cmd != CMD_RIGHT);
        end
        default: begin
          speed_l <= '0;
          speed_r <= '0;
          dir_l   <= 1'b1;
          dir_r   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nav_sequencer.sv
// Self-checking bench for nav_sequencer with shortened cross/turn timings.
module tb_nav_sequencer;
  import nav_pkg::*;

  localparam int CROSS_C = 20;
  localparam int TMIN    = 50;
  localparam int TMAX    = 1000;
  localparam int W       = 30;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, adc_valid = 1'b0, path_wr_en = 1'b0;
  logic [11:0] in0 = '0, in1 = '0, in2 = '0;
  logic [13:0] lf_speed_l = 14'd1234, lf_speed_r = 14'd4321;
  logic        lf_dir_l = 1'b1, lf_dir_r = 1'b1;
  logic [2:0]  path_wr_addr = '0;
  logic [1:0]  path_wr_cmd = '0;
  logic [13:0] speed_l, speed_r;
  logic        dir_l, dir_r, busy, done, err;
  logic [3:0]  node_cnt;
  logic [2:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  nav_sequencer #(
    .DARK_TH(1500), .NODE_DEBOUNCE(3), .CROSS_CYCLES(CROSS_C),
    .TURN_MIN(TMIN), .TURN_MAX(TMAX), .PATH_LEN(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .adc_valid(adc_valid),
    .in0(in0), .in1(in1), .in2(in2),
    .lf_speed_l(lf_speed_l), .lf_speed_r(lf_speed_r), .lf_dir_l(lf_dir_l), .lf_dir_r(lf_dir_r),
    .path_wr_en(path_wr_en), .path_wr_addr(path_wr_addr), .path_wr_cmd(path_wr_cmd),
    .speed_l(speed_l), .speed_r(speed_r), .dir_l(dir_l), .dir_r(dir_r),
    .busy(busy), .done(done), .node_cnt(node_cnt), .err(err), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_sample(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    adc_valid = 1'b1; in0 = a; in1 = b; in2 = c;
    @(negedge clk);
    adc_valid = 1'b0;
  endtask

  task automatic send_dark();
    send_sample(12'd2200, 12'd2200, 12'd2200);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic write_entry(input logic [2:0] addr, input logic [1:0] cmd);
    path_wr_en = 1'b1; path_wr_addr = addr; path_wr_cmd = cmd;
    @(negedge clk);
    path_wr_en = 1'b0;
  endtask

  task automatic wait_cross(output int n);
    n = 0;
    while (state_dbg == CROSS && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want %0d", state_dbg, IDLE); end
    checks++; if ({speed_l, speed_r, dir_l, dir_r, busy, done, node_cnt, err} !== '0) begin
      errors++; $display("FAIL rst_outputs: got sl=%0d sr=%0d dl=%0b dr=%0b busy=%0b done=%0b nc=%0d err=%0b want all 0",
                         speed_l, speed_r, dir_l, dir_r, busy, done, node_cnt, err);
    end
    @(negedge clk); rst_n = 1'b1;
    tick(2);
    checks++; if ({dir_l, dir_r, speed_l, speed_r, busy} !== {1'b1, 1'b1, 14'd0, 14'd0, 1'b0}) begin
      errors++; $display("FAIL idle_outputs: got dl=%0b dr=%0b sl=%0d sr=%0d busy=%0b want 1 1 0 0 0",
                         dir_l, dir_r, speed_l, speed_r, busy);
    end
  endtask

  task automatic test_default_table();
    pulse_start();
    checks++; if (state_dbg !== FOLLOW) begin errors++; $display("FAIL dflt_follow: got %0d want %0d", state_dbg, FOLLOW); end
    send_dark(); tick(1); send_dark(); send_dark();
    @(negedge clk);
    checks++; if (state_dbg !== DONE) begin errors++; $display("FAIL dflt_done_state: got %0d want %0d", state_dbg, DONE); end
    checks++; if (node_cnt !== 4'd1) begin errors++; $display("FAIL dflt_node_cnt: got %0d want 1", node_cnt); end
    @(negedge clk);
    checks++; if ({done, busy, speed_l, speed_r} !== {1'b1, 1'b0, 14'd0, 14'd0}) begin
      errors++; $display("FAIL dflt_done_out: got done=%0b busy=%0b sl=%0d sr=%0d want 1 0 0 0", done, busy, speed_l, speed_r);
    end
  endtask

  task automatic test_path_run();
    int n;
    write_entry(3'd0, 2'b00); write_entry(3'd1, 2'b01); write_entry(3'd2, 2'b11);
    pulse_start();
    checks++; if ({node_cnt, err} !== 5'd0) begin errors++; $display("FAIL run_start_clear: got nc=%0d err=%0b want 0 0", node_cnt, err); end
    send_dark(); send_dark(); send_dark();
    @(negedge clk);
    checks++; if (state_dbg !== CROSS) begin errors++; $display("FAIL run_n1_cross: got %0d want %0d", state_dbg, CROSS); end
    @(negedge clk);
    checks++; if ({speed_l, speed_r, dir_l, dir_r} !== {14'd5500, 14'd5500, 1'b1, 1'b1}) begin
      errors++; $display("FAIL run_cross_out: got sl=%0d sr=%0d dl=%0b dr=%0b want 5500 5500 1 1", speed_l, speed_r, dir_l, dir_r);
    end
    wait_cross(n);
    checks++; if (n + 1 !== CROSS_C) begin errors++; $display("FAIL run_cross_len: got %0d want %0d", n + 1, CROSS_C); end
    checks++; if (state_dbg !== FOLLOW) begin errors++; $display("FAIL run_n1_follow: got %0d want %0d", state_dbg, FOLLOW); end
    send_dark(); send_dark(); send_dark();
    @(negedge clk);
    wait_cross(n);
    checks++; if (state_dbg !== TURN) begin errors++; $display("FAIL run_n2_turn: got %0d want %0d", state_dbg, TURN); end
    @(negedge clk);  // cycle counter now 1
    checks++; if ({dir_l, dir_r, speed_l, speed_r} !== {1'b0, 1'b1, 14'd5500, 14'd5500}) begin
      errors++; $display("FAIL run_turn_out: got dl=%0b dr=%0b sl=%0d sr=%0d want 0 1 5500 5500", dir_l, dir_r, speed_l, speed_r);
    end
    send_dark();
    checks++; if (state_dbg !== TURN) begin errors++; $display("FAIL run_turn_early: got %0d want %0d", state_dbg, TURN); end
    tick(TMIN - 3);  // counter now TURN_MIN-1
    send_sample(12'd0, 12'd2200, 12'd0);
    checks++; if (state_dbg !== TURN) begin errors++; $display("FAIL run_turn_min_m1: got %0d want %0d", state_dbg, TURN); end
    send_sample(12'd0, 12'd2200, 12'd0);
    checks++; if (state_dbg !== FOLLOW) begin errors++; $display("FAIL run_turn_exit: got %0d want %0d", state_dbg, FOLLOW); end
    send_dark(); send_dark(); send_dark();
    @(negedge clk);
    checks++; if (state_dbg !== DONE) begin errors++; $display("FAIL run_n3_done: got %0d want %0d", state_dbg, DONE); end
    checks++; if (node_cnt !== 4'd3) begin errors++; $display("FAIL run_node_cnt: got %0d want 3", node_cnt); end
  endtask

  task automatic test_debounce();
    int n;
    pulse_start();
    send_sample(12'd1500, 12'd1500, 12'd1500);
    send_dark();
    send_sample(12'd2200, 12'd180, 12'd2200);
    send_dark();
    send_sample(12'd2200, 12'd1499, 12'd2200);
    send_dark(); send_dark();
    tick(2);
    checks++; if ({state_dbg, node_cnt} !== {FOLLOW, 4'd0}) begin
      errors++; $display("FAIL deb_no_node: got st=%0d nc=%0d want %0d 0", state_dbg, node_cnt, FOLLOW);
    end
    send_dark();
    @(negedge clk);
    checks++; if ({state_dbg, node_cnt} !== {CROSS, 4'd1}) begin
      errors++; $display("FAIL deb_node: got st=%0d nc=%0d want %0d 1", state_dbg, node_cnt, CROSS);
    end
    wait_cross(n);
    checks++; if (state_dbg !== FOLLOW) begin errors++; $display("FAIL deb_follow: got %0d want %0d", state_dbg, FOLLOW); end
  endtask

  task automatic test_follow_passthrough();
    logic [W-1:0] got, exp;
    for (int i = 0; i < 12; i++) begin
      lf_speed_l = (i == 0) ? 14'd6000 : 14'($urandom_range(0, 16383));
      lf_speed_r = 14'($urandom_range(0, 16383));
      lf_dir_l   = 1'($urandom_range(0, 1));
      lf_dir_r   = 1'($urandom_range(0, 1));
      exp_q.push_back({lf_dir_l, lf_dir_r, lf_speed_l, lf_speed_r});
      @(negedge clk);
      got = {dir_l, dir_r, speed_l, speed_r};
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL pass_%0d: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_write_while_busy();
    int n;
    write_entry(3'd1, 2'b11);
    send_dark(); send_dark(); send_dark();
    @(negedge clk);
    checks++; if (state_dbg !== CROSS) begin errors++; $display("FAIL busy_write_ignored: got %0d want %0d", state_dbg, CROSS); end
    wait_cross(n);
    checks++; if (state_dbg !== TURN) begin errors++; $display("FAIL busy_turn: got %0d want %0d", state_dbg, TURN); end
  endtask

  task automatic test_turn_timeout();
    int n = 0;
    while (state_dbg == TURN && n < 2000) begin
      adc_valid = (n % 8 == 3); in0 = 12'd0; in1 = 12'd180; in2 = 12'd0;
      n++;
      @(negedge clk);
    end
    adc_valid = 1'b0;
`ifdef NAV_ERR_TIMEOUT_EN
    checks++; if (n !== TMAX) begin errors++; $display("FAIL tmo_len: got %0d want %0d", n, TMAX); end
    checks++; if ({state_dbg, err} !== {DONE, 1'b1}) begin
      errors++; $display("FAIL tmo_done: got st=%0d err=%0b want %0d 1", state_dbg, err, DONE);
    end
    tick(3);
    checks++; if ({done, err} !== 2'b11) begin errors++; $display("FAIL tmo_hold: got done=%0b err=%0b want 1 1", done, err); end
`else
    checks++; if ({state_dbg, err} !== {TURN, 1'b0}) begin
      errors++; $display("FAIL tmo_wait: got st=%0d err=%0b after %0d clocks want %0d 0", state_dbg, err, n, TURN);
    end
`endif
  endtask

  task automatic test_reset_mid_turn();
    int n;
    if (state_dbg != TURN) begin
      pulse_start();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear_on_start: got %0b want 0", err); end
      send_dark(); send_dark(); send_dark();
      @(negedge clk);
      wait_cross(n);
      send_dark(); send_dark(); send_dark();
      @(negedge clk);
      wait_cross(n);
      checks++; if (state_dbg !== TURN) begin errors++; $display("FAIL rmt_reach_turn: got %0d want %0d", state_dbg, TURN); end
    end
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({speed_l, speed_r, dir_l, dir_r, busy, done, node_cnt, err} !== '0) begin
      errors++; $display("FAIL rmt_outputs: got sl=%0d sr=%0d dl=%0b dr=%0b busy=%0b done=%0b nc=%0d err=%0b want all 0",
                         speed_l, speed_r, dir_l, dir_r, busy, done, node_cnt, err);
    end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL rmt_state: got %0d want %0d", state_dbg, IDLE); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    send_dark(); send_dark(); send_dark();
    @(negedge clk);
    checks++; if ({state_dbg, node_cnt} !== {DONE, 4'd1}) begin
      errors++; $display("FAIL rmt_table_cleared: got st=%0d nc=%0d want %0d 1", state_dbg, node_cnt, DONE);
    end
  endtask

  // sequence and report
  initial begin
    test_reset();
    test_default_table();
    test_path_run();
    test_debounce();
    test_follow_passthrough();
    test_write_while_busy();
    test_turn_timeout();
    test_reset_mid_turn();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
